// File: rtl/instr_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Fetch front end between the synchronous instruction ROM and the decode
// stage. It walks sequential word addresses, absorbs the ROM's one-cycle read
// latency, and queues up to DEPTH {pc, instruction} pairs for the consumer.
// A redirect from execute flushes the queue and re-steers fetch.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   imem_req        read strobe to the ROM
//   imem_addr       word-aligned byte address of the read
//   imem_rdata      ROM data, valid exactly one cycle after imem_req
//   out_valid       head entry is valid
//   out_ready       consumer accepts the head entry this cycle
//   out_pc          pc of the head entry (0 while empty)
//   out_instr       instruction of the head entry (0 while empty)
//   redirect_valid  flush and re-steer request
//   redirect_pc     new fetch pc; low two bits are forced to zero
//   count           number of queued entries
//
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both 1 (unless a redirect is present, which flushes instead).
// out_valid never depends on out_ready, and out_pc/out_instr stay stable
// while out_valid is 1 and out_ready is 0.
// ----------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);

    logic [31:0]   fetch_pc_q,  fetch_pc_d;
    logic [31:0]   issued_pc_q, issued_pc_d;
    logic          inflight_q,  inflight_d;
    logic          kill_q,      kill_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_pc_d    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          not_empty;

    always_comb begin
        // Space is judged on entries already queued plus the read in flight;
        // a pop in the same cycle does not free a slot until next cycle.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        not_empty = (count_q != '0);
        issue     = reset && !redirect_valid && (occupancy < DEPTH_W);
        // A redirect flushes the queue, so the response arriving in that
        // cycle and any pop request are both discarded.
        push      = inflight_q && !kill_q && !redirect_valid;
        pop       = not_empty && out_ready && !redirect_valid;

        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        // No read launches under a redirect; kill still marks the following
        // response slot dead so nothing can ever push across a flush.
        kill_d      = redirect_valid;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;

        if (issue) begin
            issued_pc_d = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 32'd4;
        end

        if (push) begin
            mem_pc_d[wr_ptr_q]    = issued_pc_q;
            mem_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            assert (!(push && (count_q == FULL_C)));
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            kill_q      <= kill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_instr_q <= mem_instr_d;
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_valid = not_empty;
    assign out_pc    = not_empty ? mem_pc_q[rd_ptr_q]    : '0;
    assign out_instr = not_empty ? mem_instr_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule
